// File: rtl/monster_shot_mover_if.sv
// Bundles the per-slot monster shot signals between the frame/scan
// logic (master) and monster_shot_mover (slave).
//   startOfFrame    : one-cycle pulse per frame
//   fireRequest     : level, fire from the monster's current position
//   monsterX/Y      : monster top-left corner
//   collision       : one-cycle pulse, shot hit player or shield
//   pixelX/Y        : current scan pixel
//   InsideRectangle : registered, scan pixel lies inside the shot
//   offsetX/Y       : registered pixel offset inside the shot
//   shotActive      : shot is flying
//   shotX/Y         : shot top-left corner
interface monster_shot_mover_if;
  logic        startOfFrame;
  logic        fireRequest;
  logic [10:0] monsterX;
  logic [10:0] monsterY;
  logic        collision;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        InsideRectangle;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        shotActive;
  logic [10:0] shotX;
  logic [10:0] shotY;

  modport master (
    output startOfFrame, fireRequest, monsterX, monsterY, collision, pixelX, pixelY,
    input  InsideRectangle, offsetX, offsetY, shotActive, shotX, shotY
  );

  modport slave (
    input  startOfFrame, fireRequest, monsterX, monsterY, collision, pixelX, pixelY,
    output InsideRectangle, offsetX, offsetY, shotActive, shotX, shotY
  );
endinterface

// File: rtl/monster_shot_mover.sv
// Position and lifecycle of one monster shot: spawns on a fire request,
// falls SPEED_Y pixels per frame, retires on the floor or on a collision,
// then waits COOLDOWN_FRAMES frames before it may fire again. Also
// produces the registered in-rectangle flag and pixel offsets consumed
// by the monster-shot bitmap stage.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : shot signals (see monster_shot_mover_if)
module monster_shot_mover #(
  parameter int SHOT_WIDTH      = 2,
  parameter int SHOT_HEIGHT     = 4,
  parameter int SPEED_Y         = 4,
  parameter int SCREEN_BOTTOM   = 479,
  parameter int SPAWN_OFFSET_X  = 15,
  parameter int SPAWN_OFFSET_Y  = 32,
  parameter int COOLDOWN_FRAMES = 30
) (
  input logic                 clk,
  input logic                 resetN,
  monster_shot_mover_if.slave bus
);

  localparam int CNT_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [11:0] WIDTH12   = 12'(SHOT_WIDTH);
  localparam logic [11:0] HEIGHT12  = 12'(SHOT_HEIGHT);
  localparam logic [11:0] SPEED12   = 12'(SPEED_Y);
  localparam logic [11:0] BOTTOM12  = 12'(SCREEN_BOTTOM);
  localparam logic [11:0] SPAWN_X12 = 12'(SPAWN_OFFSET_X);
  localparam logic [11:0] SPAWN_Y12 = 12'(SPAWN_OFFSET_Y);

  typedef enum logic [1:0] {
    READY    = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [10:0]      shot_x_reg, shot_x_next;
  logic [10:0]      shot_y_reg, shot_y_next;
  logic             inside_reg, inside_next;
  logic [10:0]      off_x_reg, off_x_next;
  logic [10:0]      off_y_reg, off_y_next;

  logic        shot_active;
  logic [11:0] spawn_x, spawn_y, fall_y;
  logic        spawn_ok;
  logic [11:0] px12, py12, sx12, sy12;
  logic        in_x, in_y;

  assign shot_active = (state_reg == FLYING);

  // 12-bit sums expose the carry so an off-screen spawn can be rejected.
  assign spawn_x  = {1'b0, bus.monsterX} + SPAWN_X12;
  assign spawn_y  = {1'b0, bus.monsterY} + SPAWN_Y12;
  assign spawn_ok = !spawn_x[11] && !spawn_y[11] && (spawn_y <= BOTTOM12);
  assign fall_y   = {1'b0, shot_y_reg} + SPEED12;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shot_x_next = shot_x_reg;
    shot_y_next = shot_y_reg;
    case (state_reg)
      READY: begin
        if (bus.fireRequest && spawn_ok) begin
          shot_x_next = spawn_x[10:0];
          shot_y_next = spawn_y[10:0];
          state_next  = FLYING;
        end
      end
      FLYING: begin
        // A hit wins over a frame tick: the shot retires where it was.
        if (bus.collision) begin
          state_next = COOLDOWN;
          cnt_next   = CNT_LOAD;
        end else if (bus.startOfFrame) begin
          if (fall_y > BOTTOM12) begin
            state_next = COOLDOWN;
            cnt_next   = CNT_LOAD;
          end else begin
            shot_y_next = fall_y[10:0];
          end
        end
      end
      COOLDOWN: begin
        // A zero count only happens with COOLDOWN_FRAMES=0: leave at once.
        if (cnt_reg == '0) begin
          state_next = READY;
        end else if (bus.startOfFrame) begin
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_next = READY;
        end
      end
      default: begin
        state_next = COOLDOWN;
        cnt_next   = CNT_LOAD;
      end
    endcase
  end

  // Pixel test at 12 bits so shot edges near 2047 do not wrap.
  assign px12 = {1'b0, bus.pixelX};
  assign py12 = {1'b0, bus.pixelY};
  assign sx12 = {1'b0, shot_x_reg};
  assign sy12 = {1'b0, shot_y_reg};
  assign in_x = (px12 >= sx12) && (px12 < sx12 + WIDTH12);
  assign in_y = (py12 >= sy12) && (py12 < sy12 + HEIGHT12);

  always_comb begin
    inside_next = shot_active && in_x && in_y;
    off_x_next  = '0;
    off_y_next  = '0;
    if (inside_next) begin
      off_x_next = bus.pixelX - shot_x_reg;
      off_y_next = bus.pixelY - shot_y_reg;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg  <= COOLDOWN;
      cnt_reg    <= CNT_LOAD;
      shot_x_reg <= '0;
      shot_y_reg <= '0;
      inside_reg <= 1'b0;
      off_x_reg  <= '0;
      off_y_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shot_x_reg <= shot_x_next;
      shot_y_reg <= shot_y_next;
      inside_reg <= inside_next;
      off_x_reg  <= off_x_next;
      off_y_reg  <= off_y_next;
    end
  end

  assign bus.shotActive      = shot_active;
  assign bus.shotX           = shot_x_reg;
  assign bus.shotY           = shot_y_reg;
  assign bus.InsideRectangle = inside_reg;
  assign bus.offsetX         = off_x_reg;
  assign bus.offsetY         = off_y_reg;

endmodule

// File: tb/tb_monster_shot_mover.sv
module tb_monster_shot_mover;

  localparam int ST_READY    = 0;
  localparam int ST_FLYING   = 1;
  localparam int ST_COOLDOWN = 2;

  logic clk;
  logic resetN;
  int   n_cmp;
  int   n_bad;

  monster_shot_mover_if bus ();

  monster_shot_mover dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        sof;
    logic        fire;
    logic        coll;
    logic [10:0] mx;
    logic [10:0] my;
    logic [10:0] px;
    logic [10:0] py;
    logic        act;
    logic [10:0] sx;
    logic [10:0] sy;
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic drive(input logic sof, input logic fire, input logic coll,
                       input logic [10:0] mx, input logic [10:0] my,
                       input logic [10:0] px, input logic [10:0] py);
    bus.startOfFrame = sof;
    bus.fireRequest  = fire;
    bus.collision    = coll;
    bus.monsterX     = mx;
    bus.monsterY     = my;
    bus.pixelX       = px;
    bus.pixelY       = py;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 11'd0, 11'd0);
  endtask

  // One clock, outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic spawn(input logic [10:0] mx, input logic [10:0] my);
    drive(1'b0, 1'b1, 1'b0, mx, my, 11'd0, 11'd0);
    tick();
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //            sof   fire  coll  mx       my      px       py      act   sx       sy      ins   ox     oy
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 11'd100, 11'd50, 11'd0,   11'd0,  1'b1, 11'd115, 11'd82, 1'b0, 11'd0, 11'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 11'd100, 11'd50, 11'd116, 11'd85, 1'b1, 11'd115, 11'd82, 1'b1, 11'd1, 11'd3};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 11'd100, 11'd50, 11'd117, 11'd82, 1'b1, 11'd115, 11'd82, 1'b0, 11'd0, 11'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 11'd100, 11'd50, 11'd115, 11'd82, 1'b1, 11'd115, 11'd82, 1'b1, 11'd0, 11'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 11'd100, 11'd50, 11'd114, 11'd84, 1'b1, 11'd115, 11'd82, 1'b0, 11'd0, 11'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 11'd100, 11'd50, 11'd116, 11'd86, 1'b1, 11'd115, 11'd82, 1'b0, 11'd0, 11'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 11'd0,   11'd0,  11'd115, 11'd85, 1'b1, 11'd115, 11'd82, 1'b1, 11'd0, 11'd3};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 11'd100, 11'd50, 11'd116, 11'd85, 1'b1, 11'd115, 11'd86, 1'b1, 11'd1, 11'd3};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 11'd100, 11'd50, 11'd116, 11'd85, 1'b1, 11'd115, 11'd86, 1'b0, 11'd0, 11'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 11'd100, 11'd50, 11'd116, 11'd89, 1'b1, 11'd115, 11'd86, 1'b1, 11'd1, 11'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 11'd100, 11'd50, 11'd116, 11'd86, 1'b0, 11'd115, 11'd86, 1'b1, 11'd1, 11'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 11'd100, 11'd50, 11'd116, 11'd86, 1'b0, 11'd115, 11'd86, 1'b0, 11'd0, 11'd0};

    // Reset state
    idle();
    resetN = 1'b0;
    tick();
    tick();
    chk("rst_active", int'(bus.shotActive), 0);
    chk("rst_shotx", int'(bus.shotX), 0);
    chk("rst_shoty", int'(bus.shotY), 0);
    chk("rst_inside", int'(bus.InsideRectangle), 0);
    chk("rst_state", int'(dut.state_reg), ST_COOLDOWN);
    resetN = 1'b1;
    tick();

    // Cooldown count: 29 frames keep COOLDOWN (fire ignored), 30th frees the slot
    frames(29);
    chk("cd29_state", int'(dut.state_reg), ST_COOLDOWN);
    spawn(11'd100, 11'd50);
    chk("cd_fire_ignored", int'(bus.shotActive), 0);
    frames(1);
    chk("cd30_state", int'(dut.state_reg), ST_READY);

    // Spawn, pixel test and a frame step from the vector table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].sof, tbl[i].fire, tbl[i].coll, tbl[i].mx, tbl[i].my, tbl[i].px, tbl[i].py);
      tick();
      chk($sformatf("v%0d_active", i), int'(bus.shotActive), int'(tbl[i].act));
      chk($sformatf("v%0d_shotx", i), int'(bus.shotX), int'(tbl[i].sx));
      chk($sformatf("v%0d_shoty", i), int'(bus.shotY), int'(tbl[i].sy));
      chk($sformatf("v%0d_inside", i), int'(bus.InsideRectangle), int'(tbl[i].ins));
      chk($sformatf("v%0d_offx", i), int'(bus.offsetX), int'(tbl[i].ox));
      chk($sformatf("v%0d_offy", i), int'(bus.offsetY), int'(tbl[i].oy));
    end
    idle();
    chk("coll_state", int'(dut.state_reg), ST_COOLDOWN);

    // Collision wins over a simultaneous frame tick
    frames(30);
    spawn(11'd100, 11'd168);
    chk("prio_spawn_y", int'(bus.shotY), 200);
    drive(1'b1, 1'b0, 1'b1, 11'd0, 11'd0, 11'd0, 11'd0);
    tick();
    idle();
    chk("prio_state", int'(dut.state_reg), ST_COOLDOWN);
    chk("prio_shoty", int'(bus.shotY), 200);
    chk("prio_active", int'(bus.shotActive), 0);
    spawn(11'd10, 11'd10);
    chk("prio_fire_ignored", int'(bus.shotActive), 0);
    chk("prio_fire_shoty", int'(bus.shotY), 200);

    // Fall to the floor from 470
    frames(30);
    spawn(11'd100, 11'd438);
    chk("fall_spawn_y", int'(bus.shotY), 470);
    frames(1);
    chk("fall1_y", int'(bus.shotY), 474);
    chk("fall1_active", int'(bus.shotActive), 1);
    frames(1);
    chk("fall2_y", int'(bus.shotY), 478);
    chk("fall2_active", int'(bus.shotActive), 1);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    chk("fall3_y", int'(bus.shotY), 478);
    chk("fall3_active", int'(bus.shotActive), 0);
    chk("fall3_state", int'(dut.state_reg), ST_COOLDOWN);
    tick();

    // Illegal spawns: Y past the floor, X past 11 bits; then the last legal row
    frames(30);
    spawn(11'd100, 11'd460);
    chk("illegal_y_active", int'(bus.shotActive), 0);
    chk("illegal_y_state", int'(dut.state_reg), ST_READY);
    spawn(11'd2040, 11'd50);
    chk("illegal_x_active", int'(bus.shotActive), 0);
    spawn(11'd100, 11'd447);
    chk("edge_spawn_active", int'(bus.shotActive), 1);
    chk("edge_spawn_y", int'(bus.shotY), 479);
    frames(1);
    chk("edge_retire_state", int'(dut.state_reg), ST_COOLDOWN);
    chk("edge_retire_y", int'(bus.shotY), 479);

    // Asynchronous reset mid-flight
    frames(30);
    spawn(11'd100, 11'd50);
    drive(1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 11'd116, 11'd85);
    tick();
    chk("ar_pre_inside", int'(bus.InsideRectangle), 1);
    #2;
    resetN = 1'b0;
    #1;
    chk("ar_active", int'(bus.shotActive), 0);
    chk("ar_inside", int'(bus.InsideRectangle), 0);
    chk("ar_shotx", int'(bus.shotX), 0);
    chk("ar_shoty", int'(bus.shotY), 0);
    chk("ar_offx", int'(bus.offsetX), 0);
    chk("ar_offy", int'(bus.offsetY), 0);
    idle();
    tick();
    resetN = 1'b1;
    tick();
    chk("ar_state", int'(dut.state_reg), ST_COOLDOWN);
    frames(29);
    chk("ar_cd29_state", int'(dut.state_reg), ST_COOLDOWN);
    frames(1);
    chk("ar_cd30_state", int'(dut.state_reg), ST_READY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
